exponent_difference: RTL and testbench
======================================

Name: exponent_difference

Overview:
Registered exponent-comparison stage of the floating-point HUB adder. It takes the biased exponents of operands X and Y and produces:
- the signed difference Ex−Ey;
- the operand-order flag;
- the magnitude of the difference;
- a saturated alignment shift amount for the mantissa shifter.

It sits between operand unpacking and the swap/alignment stage, with one clock of latency.

Parameters:
E, 8, exponent width in bits (≥2)
M, 23, mantissa field width; alignment shift saturates at M+2
SW, $clog2(M+3), width of shift_amt (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  Ex/Ey valid this cycle
Ex  input  E  biased exponent of X, unsigned
Ey  input  E  biased exponent of Y, unsigned
out_valid  output  1  registered outputs correspond to an accepted input
dif  output  E+1  signed two's-complement Ex−Ey
X_greater_than_Y  output  1  1 when Ex ≥ Ey
abs_dif  output  E  |Ex−Ey|, unsigned
shift_amt  output  SW  min(abs_dif, M+2)
shift_sat  output  1  1 when abs_dif > M+2

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0, all outputs are cleared immediately:
  - out_valid=0, dif=0, X_greater_than_Y=0, abs_dif=0, shift_amt=0, shift_sat=0.
  - They stay cleared until the first rising clk edge with rst_n=1.
- Latency is 1 cycle. If in_valid=1 at rising edge N, the results for that Ex/Ey are visible after edge N, and out_valid=1 in that same cycle.
- out_valid is in_valid registered every cycle. There is no back-pressure.
- Data outputs load only when in_valid=1. When in_valid=0 they hold their previous values, but out_valid=0.
- Arithmetic:
  - Zero-extend Ex and Ey to E+1 bits.
  - dif = Ex−Ey in E+1 bits; this is always exact, with range −(2^E−1)..+(2^E−1).
  - X_greater_than_Y = ~dif[E], i.e. sign bit clear.
  - Equal exponents give X_greater_than_Y=1 and dif=0. This means X is treated as the larger operand, so no swap occurs downstream.
  - abs_dif = dif when dif[E]=0, otherwise −dif. It is truncated to E bits, which is lossless because the magnitude is ≤ 2^E−1.
  - shift_sat = (abs_dif > M+2).
  - shift_amt = shift_sat ? M+2 : abs_dif[SW-1:0].
- All outputs are consistent with the same captured input pair. No output is combinational from the inputs.
- Reset asserted mid-stream: outputs clear immediately, and any transaction in flight is discarded. No output is produced for it.
- Back-to-back in_valid: every cycle yields a new result, with full throughput.
- X or Z on Ex/Ey while in_valid=0 must not propagate into the held outputs.

Test Plan:
- Ex=13, Ey=7, in_valid=1 → next cycle: out_valid=1, dif=+6 (0_0000_0110), X_greater_than_Y=1, abs_dif=6, shift_amt=6, shift_sat=0.
- Ex=7, Ey=13 → dif=−6 (1_1111_1010), X_greater_than_Y=0, abs_dif=6, shift_amt=6, shift_sat=0.
- Ex=13, Ey=13 → dif=0, X_greater_than_Y=1, abs_dif=0, shift_amt=0, shift_sat=0.
- Extremes:
  - Ex=255, Ey=0 → dif=+255, X_greater_than_Y=1, abs_dif=255, shift_amt=25, shift_sat=1.
  - Ex=0, Ey=255 → dif=−255 (1_0000_0001), X_greater_than_Y=0, abs_dif=255.
- Saturation boundary (M=23): abs_dif=25 → shift_amt=25, shift_sat=0; abs_dif=26 → shift_amt=25, shift_sat=1.
- Handshake and reset:
  - Stream 3 back-to-back valid pairs, then in_valid=0 for 2 cycles → three consecutive out_valid=1 with correct results, then out_valid=0 with data held.
  - Assert rst_n=0 between clock edges → all outputs 0 immediately, with no result for the in-flight pair.

Source files
------------

// File: rtl/exponent_difference.sv
// Exponent comparison stage of the HUB floating-point adder.
// Registers Ex-Ey, order flag, magnitude and saturated shift amount.
module exponent_difference #(
  parameter  int E  = 8,
  parameter  int M  = 23,
  localparam int SW = $clog2(M + 3)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [E-1:0]  Ex,
  input  logic [E-1:0]  Ey,
  output logic          out_valid,
  output logic [E:0]    dif,
  output logic          X_greater_than_Y,
  output logic [E-1:0]  abs_dif,
  output logic [SW-1:0] shift_amt,
  output logic          shift_sat
);

  localparam int SMAX = M + 2;

  logic [E:0]    dif_c;
  logic [E-1:0]  abs_c;
  logic          sat_c;
  logic [SW-1:0] amt_c;

  // magnitude never exceeds 2^E-1, so dropping the top bit is lossless
  always_comb begin
    dif_c = {1'b0, Ex} - {1'b0, Ey};
    abs_c = E'(dif_c[E] ? -dif_c : dif_c);
    sat_c = 32'(abs_c) > SMAX;
    amt_c = sat_c ? SW'(SMAX) : SW'(abs_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      dif              <= '0;
      X_greater_than_Y <= 1'b0;
      abs_dif          <= '0;
      shift_amt        <= '0;
      shift_sat        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dif              <= dif_c;
        X_greater_than_Y <= ~dif_c[E];
        abs_dif          <= abs_c;
        shift_amt        <= amt_c;
        shift_sat        <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_exponent_difference.sv
// Randomized and directed bench for exponent_difference,
// checked against an integer-arithmetic reference model.
module tb_exponent_difference;

  localparam int E  = 8;
  localparam int M  = 23;
  localparam int SW = $clog2(M + 3);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [E-1:0]  Ex = '0;
  logic [E-1:0]  Ey = '0;
  logic          out_valid;
  logic [E:0]    dif;
  logic          X_greater_than_Y;
  logic [E-1:0]  abs_dif;
  logic [SW-1:0] shift_amt;
  logic          shift_sat;

  exponent_difference #(.E(E), .M(M)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .Ex(Ex),
    .Ey(Ey),
    .out_valid(out_valid),
    .dif(dif),
    .X_greater_than_Y(X_greater_than_Y),
    .abs_dif(abs_dif),
    .shift_amt(shift_amt),
    .shift_sat(shift_sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic          e_valid;
  logic [E:0]    e_dif;
  logic          e_gt;
  logic [E-1:0]  e_abs;
  logic [SW-1:0] e_amt;
  logic          e_sat;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    e_valid = 0; e_dif = '0; e_gt = 0;
    e_abs = '0; e_amt = '0; e_sat = 0;
  endtask

  task automatic model(input logic v, input logic [E-1:0] ex,
                       input logic [E-1:0] ey);
    int d, a;
    e_valid = v;
    if (v) begin
      d = int'(ex) - int'(ey);
      a = (d < 0) ? -d : d;
      e_dif = (E+1)'(d);
      e_gt  = (d >= 0);
      e_abs = E'(a);
      e_sat = (a > M + 2);
      e_amt = SW'(e_sat ? M + 2 : a);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, ".dif"}, 32'(dif), 32'(e_dif));
    check({tag, ".xgy"}, 32'(X_greater_than_Y), 32'(e_gt));
    check({tag, ".abs"}, 32'(abs_dif), 32'(e_abs));
    check({tag, ".amt"}, 32'(shift_amt), 32'(e_amt));
    check({tag, ".sat"}, 32'(shift_sat), 32'(e_sat));
  endtask

  task automatic step(input logic v, input logic [E-1:0] ex,
                      input logic [E-1:0] ey, input string tag);
    @(negedge clk);
    in_valid = v; Ex = ex; Ey = ey;
    @(posedge clk);
    model(v, ex, ey);
    #1 check_all(tag);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    step(1, 8'd13, 8'd7, "pos6");
    step(1, 8'd7, 8'd13, "neg6");
    step(1, 8'd13, 8'd13, "equal");
    step(1, 8'd255, 8'd0, "max");
    step(1, 8'd0, 8'd255, "min");
    step(1, 8'd30, 8'd5, "abs25");
    step(1, 8'd5, 8'd31, "abs26");
    step(1, 8'd40, 8'd16, "abs24");

    step(1, 8'd100, 8'd50, "b2b0");
    step(1, 8'd50, 8'd100, "b2b1");
    step(1, 8'd200, 8'd199, "b2b2");
    step(0, 8'bx, 8'bx, "holdx");
    step(0, 8'd3, 8'd250, "hold");

    for (int i = 0; i < 300; i++) begin
      logic v;
      logic [E-1:0] a, b;
      v = ($urandom_range(0, 3) != 0);
      a = E'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a + E'($urandom_range(0, 30)) : E'($urandom);
      step(v, a, b, "rand");
    end

    // reset landing between edges with a pair in flight
    step(1, 8'd9, 8'd1, "pre_rst");
    @(negedge clk);
    in_valid = 1; Ex = 8'd100; Ey = 8'd3;
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1; in_valid = 0;
    step(0, 8'd0, 8'd0, "post_rst");
    step(1, 8'd2, 8'd60, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
